control_sequencer: RTL and testbench

//  Control unit driving the ALU-system datapath (RF, ALU, ARF, IR, Memory, muxes A/B/C).

---
 rtl/control_sequencer_if.sv | 40 ++++
 rtl/control_sequencer.sv | 128 ++++++++++++
 tb/tb_control_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/control_sequencer_if.sv
// Control bus between the sequencer and the ALU-system datapath.
// master = sequencer side, slave = datapath side.
interface control_sequencer_if;
  logic [15:0] IROut;
  logic [3:0]  ALU_Flags;
  logic [2:0]  RF_OutASel;
  logic [2:0]  RF_OutBSel;
  logic [2:0]  RF_FunSel;
  logic [3:0]  RF_RegSel;
  logic [3:0]  RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel;
  logic [1:0]  ARF_OutDSel;
  logic [2:0]  ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_LH;
  logic        IR_Write;
  logic        Mem_WR;
  logic        Mem_CS;
  logic [1:0]  MuxASel;
  logic [1:0]  MuxBSel;
  logic        MuxCSel;
  logic [1:0]  SeqT;
  logic        Halted;

  modport master (
    input  IROut, ALU_Flags,
    output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel, ALU_FunSel, ALU_WF,
           ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Write, Mem_WR, Mem_CS,
           MuxASel, MuxBSel, MuxCSel, SeqT, Halted
  );

  modport slave (
    output IROut, ALU_Flags,
    input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel, ALU_FunSel, ALU_WF,
           ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel, IR_LH, IR_Write, Mem_WR, Mem_CS,
           MuxASel, MuxBSel, MuxCSel, SeqT, Halted
  );
endinterface

// File: rtl/control_sequencer.sv
// Control unit for the ALU-system datapath: two-byte fetch into IR, then a T2/T3 execute step.
// All control outputs are combinational decodes of the sequencer state, IROut and ALU_Flags.
module control_sequencer (
  input  logic                       Clock,
  input  logic                       Reset,
  control_sequencer_if.master        bus
);
  localparam logic [2:0] FUN_HOLD  = 3'b000;
  localparam logic [2:0] FUN_LOAD  = 3'b010;
  localparam logic [2:0] FUN_INC   = 3'b001;
  localparam logic [4:0] ALU_PASSA = 5'b00000;
  localparam logic [4:0] ALU_ADD   = 5'b00100;
  localparam logic [1:0] SEL_PC    = 2'b00;
  localparam logic [1:0] SEL_AR    = 2'b01;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e     state_q;
  logic [1:0] t_q;

  logic [3:0] op;
  logic [1:0] rd, rs1, rs2;
  assign op  = bus.IROut[15:12];
  assign rd  = bus.IROut[11:10];
  assign rs1 = bus.IROut[9:8];
  assign rs2 = bus.IROut[7:6];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= StRun;
      t_q     <= 2'd0;
    end else if (state_q == StRun) begin
      unique case (t_q)
        2'd0: t_q <= 2'd1;
        2'd1: t_q <= 2'd2;
        2'd2: begin
          if (op == 4'hF) begin
            state_q <= StHalt;
            t_q     <= 2'd0;
          end else if (op == 4'h3 || op == 4'h4) begin
            t_q <= 2'd3;
          end else begin
            t_q <= 2'd0;
          end
        end
        default: t_q <= 2'd0;
      endcase
    end
  end

  always_comb begin
    bus.RF_OutASel  = 3'b000;
    bus.RF_OutBSel  = 3'b000;
    bus.RF_FunSel   = FUN_HOLD;
    bus.RF_RegSel   = 4'b0000;
    bus.RF_ScrSel   = 4'b0000;
    bus.ALU_FunSel  = ALU_PASSA;
    bus.ALU_WF      = 1'b0;
    bus.ARF_OutCSel = 2'b00;
    bus.ARF_OutDSel = 2'b00;
    bus.ARF_FunSel  = FUN_HOLD;
    bus.ARF_RegSel  = 3'b000;
    bus.IR_LH       = 1'b0;
    bus.IR_Write    = 1'b0;
    bus.Mem_WR      = 1'b0;
    bus.Mem_CS      = 1'b1;
    bus.MuxASel     = 2'b00;
    bus.MuxBSel     = 2'b00;
    bus.MuxCSel     = 1'b0;
    bus.SeqT        = 2'd0;
    bus.Halted      = !Reset && (state_q == StHalt);

    // Reset overrides the decode immediately so an aborted instruction writes nothing.
    if (!Reset && state_q == StRun) begin
      bus.SeqT = t_q;
      if (t_q[1] == 1'b0) begin
        bus.ARF_OutDSel = SEL_PC;
        bus.Mem_CS      = 1'b0;
        bus.IR_Write    = 1'b1;
        bus.IR_LH       = t_q[0];
        bus.ARF_RegSel  = 3'b100;
        bus.ARF_FunSel  = FUN_INC;
      end else begin
        case (op)
          4'h1, 4'h2: begin
            bus.RF_OutASel = {1'b0, rs1};
            bus.MuxASel    = 2'b00;
            bus.RF_FunSel  = FUN_LOAD;
            bus.RF_RegSel  = 4'b0001 << rd;
            if (op == 4'h2) begin
              bus.RF_OutBSel = {1'b0, rs2};
              bus.ALU_FunSel = ALU_ADD;
              bus.ALU_WF     = 1'b1;
            end
          end
          4'h3: begin
            bus.ARF_OutDSel = SEL_AR;
            bus.Mem_CS      = 1'b0;
            if (t_q == 2'd3) begin
              bus.MuxASel   = 2'b10;
              bus.RF_FunSel = FUN_LOAD;
              bus.RF_RegSel = 4'b0001 << rd;
            end
          end
          4'h4: begin
            bus.RF_OutASel  = {1'b0, rs1};
            bus.ALU_FunSel  = ALU_PASSA;
            bus.MuxCSel     = t_q[0];   // low byte at T2, high byte at T3
            bus.ARF_OutDSel = SEL_AR;
            bus.Mem_CS      = 1'b0;
            bus.Mem_WR      = 1'b1;
            bus.ARF_RegSel  = 3'b010;
            bus.ARF_FunSel  = FUN_INC;
          end
          4'h5, 4'h6: begin
            if (op == 4'h5 || bus.ALU_Flags[3]) begin
              bus.ARF_OutCSel = SEL_AR;
              bus.MuxBSel     = 2'b01;
              bus.ARF_RegSel  = 3'b100;
              bus.ARF_FunSel  = FUN_LOAD;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_control_sequencer.sv
// Directed plus randomized bench for control_sequencer against an instruction-level model.
module tb_control_sequencer;
  logic Clock = 1'b0;
  logic Reset = 1'b1;
  control_sequencer_if bus ();

  control_sequencer dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [2:0] a_sel;  logic [2:0] b_sel;  logic [2:0] rf_fun; logic [3:0] rf_reg;
    logic [3:0] rf_scr; logic [4:0] alu_fun; logic alu_wf;
    logic [1:0] c_sel;  logic [1:0] d_sel;  logic [2:0] arf_fun; logic [2:0] arf_reg;
    logic ir_lh; logic ir_wr; logic mem_wr; logic mem_cs;
    logic [1:0] mux_a; logic [1:0] mux_b; logic mux_c; logic [1:0] seq_t; logic halted;
  } ctl_t;

  int vectors = 0;
  int miscompares = 0;
  // Model: position within the current instruction and whether the machine is parked.
  int m_step = 0;
  bit m_halt = 1'b0;

  function automatic ctl_t observed();
    ctl_t c;
    c = '{bus.RF_OutASel, bus.RF_OutBSel, bus.RF_FunSel, bus.RF_RegSel, bus.RF_ScrSel,
          bus.ALU_FunSel, bus.ALU_WF, bus.ARF_OutCSel, bus.ARF_OutDSel, bus.ARF_FunSel,
          bus.ARF_RegSel, bus.IR_LH, bus.IR_Write, bus.Mem_WR, bus.Mem_CS, bus.MuxASel,
          bus.MuxBSel, bus.MuxCSel, bus.SeqT, bus.Halted};
    return c;
  endfunction

  function automatic ctl_t idle();
    ctl_t c = '0;
    c.mem_cs = 1'b1;
    return c;
  endfunction

  // Expected controls straight from the instruction-level rules.
  function automatic ctl_t ref_ctl(bit rst, bit halt, int step, logic [15:0] ir,
                                   logic [3:0] fl);
    ctl_t c = idle();
    int op  = int'(ir[15:12]);
    int rd  = int'(ir[11:10]);
    int rs1 = int'(ir[9:8]);
    int rs2 = int'(ir[7:6]);
    if (rst) return c;
    if (halt) begin
      c.halted = 1'b1;
      return c;
    end
    c.seq_t = 2'(step);
    if (step < 2) begin
      c.mem_cs = 0; c.ir_wr = 1; c.ir_lh = (step == 1); c.arf_reg = 3'b100; c.arf_fun = 3'b001;
      return c;
    end
    if (op == 1 || op == 2) begin
      c.a_sel = 3'(rs1); c.rf_fun = 3'b010; c.rf_reg = 4'(1 << rd);
      if (op == 2) begin c.b_sel = 3'(rs2); c.alu_fun = 5'b00100; c.alu_wf = 1; end
    end else if (op == 3) begin
      c.d_sel = 2'b01; c.mem_cs = 0;
      if (step == 3) begin c.mux_a = 2'b10; c.rf_fun = 3'b010; c.rf_reg = 4'(1 << rd); end
    end else if (op == 4) begin
      c.a_sel = 3'(rs1); c.mux_c = (step == 3); c.d_sel = 2'b01; c.mem_cs = 0; c.mem_wr = 1;
      c.arf_reg = 3'b010; c.arf_fun = 3'b001;
    end else if (op == 5 || (op == 6 && fl[3])) begin
      c.c_sel = 2'b01; c.mux_b = 2'b01; c.arf_reg = 3'b100; c.arf_fun = 3'b010;
    end
    return c;
  endfunction

  function automatic int instr_len(logic [15:0] ir);
    return (ir[15:12] == 4'h3 || ir[15:12] == 4'h4) ? 4 : 3;
  endfunction

  task automatic check(input string tag);
    ctl_t exp_c = ref_ctl(Reset, m_halt, m_step, bus.IROut, bus.ALU_Flags);
    ctl_t obs_c = observed();
    vectors++;
    assert (obs_c === exp_c) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h (step %0d ir %h)", tag, obs_c, exp_c, m_step,
             bus.IROut);
    end
  endtask

  // Model update for one rising edge, using the inputs held across that edge.
  task automatic advance();
    if (Reset) begin
      m_step = 0; m_halt = 0;
    end else if (!m_halt) begin
      if (m_step == 2 && bus.IROut[15:12] == 4'hF) begin
        m_halt = 1; m_step = 0;
      end else begin
        m_step = (m_step + 1) % instr_len(bus.IROut);
      end
    end
  endtask

  task automatic step(input string tag);
    @(negedge Clock);
    check(tag);
    @(posedge Clock);
    #1;
    advance();
  endtask

  task automatic run_instr(input logic [15:0] ir, input logic [3:0] fl, input string tag);
    bus.IROut = ir;
    bus.ALU_Flags = fl;
    for (int i = 0; i < 6; i++) begin
      step(tag);
      if (m_step == 0 || m_halt) return;
    end
    vectors++;
    miscompares++;
    $error("FAIL %s_bound observed=step%0d expected=step0", tag, m_step);
  endtask

  initial begin
    bus.IROut = 16'h0000;
    bus.ALU_Flags = 4'h0;
    #2;
    check("reset_idle");
    @(posedge Clock); #1; advance();
    check("reset_held");
    Reset = 1'b0;
    #1;

    run_instr(16'h2600, 4'h0, "add");
    run_instr(16'h4100, 4'h0, "stm");
    run_instr(16'h6000, 4'h8, "beq_taken");
    run_instr(16'h6000, 4'h7, "beq_not");
    run_instr(16'h3E00, 4'h0, "ldm");
    run_instr(16'h1B00, 4'h0, "mov");
    run_instr(16'h5000, 4'h0, "bra");
    run_instr(16'h9FFF, 4'hF, "nop_alias");
    run_instr(16'hF000, 4'h0, "hlt");
    bus.IROut = 16'h2600;
    for (int i = 0; i < 20; i++) step("halted");
    Reset = 1'b1;
    step("halt_reset");
    Reset = 1'b0;
    run_instr(16'h0000, 4'h0, "nop_after_halt");

    // Abort STM with an asynchronous reset in the middle of T2.
    bus.IROut = 16'h4100;
    step("abort_t0");
    step("abort_t1");
    @(negedge Clock);
    check("abort_t2");
    Reset = 1'b1;
    #1;
    check("abort_idle");
    @(posedge Clock); #1; advance();
    Reset = 1'b0;
    step("abort_refetch_t0");
    step("abort_refetch_t1");
    step("abort_retry_t2");
    step("abort_retry_t3");

    // Randomized traffic: new instruction at each T0, random flags, occasional reset.
    for (int i = 0; i < 1500; i++) begin
      if (m_step == 0 && !m_halt) begin
        bus.IROut = 16'($urandom);
        if ($urandom_range(0, 9) != 0 && bus.IROut[15:12] == 4'hF) bus.IROut[15:12] = 4'h2;
      end
      bus.ALU_Flags = 4'($urandom);
      Reset = ($urandom_range(0, 39) == 0) || (m_halt && $urandom_range(0, 4) == 0);
      step("random");
    end
    Reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
